// File: rtl/cdc_word_sender.sv
// Source half of a toggle req/ack CDC: latches one word, toggles req, waits for the synchronized ack toggle.
// Optional ack watchdog with sticky timeout and ERROR state: define CDC_ACK_TIMEOUT_EN.
module cdc_word_sender #(
   parameter int DATA_WIDTH     = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] xfer_data_o,
   output logic                  xfer_req_o,
   input  logic                  xfer_ack_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  timeout_o
);

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("cdc_word_sender: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

`ifdef CDC_ACK_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK, S_ERROR} state_t;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q;
   assign cnt_d     = cnt_q + CNT_W'(1);
   assign timeout_o = timeout_q;
`else
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK} state_t;
   assign timeout_o = 1'b0;
`endif

   state_t                  state_q;
   logic [SYNC_STAGES-1:0]  ack_sync_q;
   logic                    ack_prev_q;
   logic                    ack_s, ack_event;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    req_q, ready_q, busy_q, done_q;

   assign ack_s     = ack_sync_q[SYNC_STAGES-1];
   assign ack_event = ack_s ^ ack_prev_q;

   assign xfer_data_o = data_q;
   assign xfer_req_o  = req_q;
   assign ready_out   = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ack_sync_q <= '0;
         ack_prev_q <= 1'b0;
         data_q     <= '0;
         req_q      <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CDC_ACK_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_i};
         ack_prev_q <= ack_s;
         done_q     <= 1'b0;
         case (state_q)
            // Ack edges seen here are stale or spurious and are consumed by ack_prev_q.
            S_IDLE: begin
               if (valid_in) begin
                  data_q  <= data_in;
                  state_q <= S_LAUNCH;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_LAUNCH: begin
               req_q   <= ~req_q;
               state_q <= S_WAIT_ACK;
`ifdef CDC_ACK_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_WAIT_ACK: begin
               if (ack_event) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
`ifdef CDC_ACK_TIMEOUT_EN
               else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_ERROR;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
`endif
            end
`ifdef CDC_ACK_TIMEOUT_EN
            // Terminal until reset; the far side state is unknown.
            S_ERROR: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
`endif
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
